instr_fetch_unit: RTL and testbench

- Producer end of the instruction → ControlUnit interface.
- Holds the PC and fetches 32-bit instruction words from instruction memory over a request/grant/response handshake.
- Presents each word, plus its opcode and fn fields, to the decode stage over a valid/ready handshake.
- Accepts redirects (branch, call, ret) from execute, flushing any fetched or in-flight instruction.

---
 rtl/risc_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// word geometry and the fetch FSM state encoding.
package risc_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, redirect input and
// the decode-side valid/ready channel. master = fetch unit, slave = its peers.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    import risc_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;

    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [ADDR_W-1:0]   out_pc;
    logic [5:0]          out_opcode;
    logic [5:0]          out_fn;
    logic [CNT_W-1:0]    deliv_cnt;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
               out_opcode, out_fn, deliv_cnt,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc,
               out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
               out_opcode, out_fn, deliv_cnt,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc,
               out_ready
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: word-aligned redirect load takes priority over the
// sequential +4 step; wraps naturally at the top of the address space.
module fetch_pc_reg
    import risc_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {target_i[ADDR_W-1:2], 2'b00};
        end else if (incr_i) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, single-entry
// output buffer to decode, redirects flush fetched or in-flight words.
//
// state  | meaning
// S_REQ  | requesting pc from memory, waiting for grant
// S_WAIT | request granted, waiting for response data
// S_FULL | instruction held for decode
// S_DROP | redirected while in flight, discarding the stale response
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  opc_pc_q, opc_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc;
    logic               pc_incr;
    logic               capture;
    logic               cnt_incr;
    logic               req_c;
    logic               valid_c;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (bus.redirect),
        .target_i (bus.redirect_pc),
        .incr_i   (pc_incr),
        .pc_o     (pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_incr  = 1'b0;
        capture  = 1'b0;
        cnt_incr = 1'b0;
        req_c    = 1'b0;
        valid_c  = 1'b0;
        case (state_q)
            S_REQ: begin
                req_c = !bus.redirect;
                if (!bus.redirect && bus.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (bus.redirect) begin
                        state_d = S_REQ;
                    end else begin
                        capture = 1'b1;
                        pc_incr = 1'b1;
                        state_d = S_FULL;
                    end
                end else if (bus.redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_FULL: begin
                valid_c = 1'b1;
                // A redirect kills the held word even if decode takes it now.
                if (bus.redirect) begin
                    state_d = S_REQ;
                end else if (bus.out_ready) begin
                    cnt_incr = 1'b1;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        instr_d  = capture  ? bus.imem_rdata : instr_q;
        opc_pc_d = capture  ? pc             : opc_pc_q;
        cnt_d    = cnt_incr ? cnt_q + 1'b1   : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            instr_q  <= '0;
            opc_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            opc_pc_q <= opc_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.imem_req   = req_c & rst;
    assign bus.imem_addr  = {pc[ADDR_W-1:2], 2'b00};
    assign bus.out_valid  = valid_c;
    assign bus.out_instr  = instr_q;
    assign bus.out_pc     = opc_pc_q;
    assign bus.out_opcode = instr_q[OPC_HI:OPC_LO];
    assign bus.out_fn     = instr_q[FN_HI:FN_LO];
    assign bus.deliv_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset and PC wrap
// sequences, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    instr_fetch_unit_if #(.ADDR_W(32), .CNT_W(16)) wbus ();

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus));

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(16))
        dut_wrap (.clk(clk), .rst(rst), .bus(wbus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    typedef struct {
        logic        rst, gnt, rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic g, logic v, logic [31:0] d,
                                logic rd, logic [31:0] rp, logic rdy,
                                logic eq, logic [31:0] ea, logic ev,
                                logic [31:0] ep, logic [31:0] ei, logic [15:0] ec);
        vec_t t;
        t.rst = r; t.gnt = g; t.rv = v; t.rdata = d; t.redir = rd; t.rpc = rp;
        t.ready = rdy; t.e_req = eq; t.e_addr = ea; t.e_valid = ev;
        t.e_pc = ep; t.e_instr = ei; t.e_cnt = ec;
        return t;
    endfunction

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[9:2] ^ 8'h3C, a[31:24], a[17:10], a[7:0]} ^ 32'h9E37_79B9;
    endfunction

    vec_t tbl[$];

    task automatic drive(input logic g, input logic v, input logic [31:0] d,
                         input logic rd, input logic [31:0] rp, input logic rdy);
        bus.imem_gnt = g; bus.imem_rvalid = v; bus.imem_rdata = d;
        bus.redirect = rd; bus.redirect_pc = rp; bus.out_ready = rdy;
    endtask

    localparam logic [31:0] I1 = 32'h0400_0000;
    localparam logic [31:0] I2 = 32'h1234_5678;

    // Random-phase model state
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
    logic        m_pend;
    int          m_wait;
    logic [31:0] m_addr;
    logic        s_req, s_gnt, s_rv, s_stab;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        g, rdy, rd, rv;
    logic [31:0] rp;
    logic [31:0] ins;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        wbus.imem_gnt = 0; wbus.imem_rvalid = 0; wbus.imem_rdata = 0;
        wbus.redirect = 0; wbus.redirect_pc = 0; wbus.out_ready = 0;

        tbl.push_back(mk(0,0,0,0,            0,0,0, 0,32'h000,0,32'h000,0,0));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h000,0,32'h000,0,0));
        tbl.push_back(mk(1,0,1,32'h41,       0,0,1, 0,32'h000,0,32'h000,0,0));
        tbl.push_back(mk(1,0,0,0,            0,0,1, 0,32'h004,1,32'h000,32'h41,0));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h004,0,32'h000,32'h41,1));
        tbl.push_back(mk(1,0,1,I1,           0,0,1, 0,32'h004,0,32'h000,32'h41,1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1,1,0,0,        0,0,0, 0,32'h008,1,32'h004,I1,1));
        tbl.push_back(mk(1,0,0,0,            0,0,1, 0,32'h008,1,32'h004,I1,1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,0,        0,0,1, 1,32'h008,0,32'h004,I1,2));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h008,0,32'h004,I1,2));
        tbl.push_back(mk(1,0,0,0,            1,32'h103,1, 0,32'h008,0,32'h004,I1,2));
        tbl.push_back(mk(1,0,1,32'hDEADBEEF, 0,0,1, 0,32'h100,0,32'h004,I1,2));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h100,0,32'h004,I1,2));
        tbl.push_back(mk(1,0,1,I2,           0,0,1, 0,32'h100,0,32'h004,I1,2));
        tbl.push_back(mk(1,0,0,0,            1,32'h200,1, 0,32'h104,1,32'h100,I2,2));
        tbl.push_back(mk(1,0,0,0,            0,0,1, 1,32'h200,0,32'h100,I2,2));
        tbl.push_back(mk(1,1,0,0,            1,32'h301,1, 0,32'h200,0,32'h100,I2,2));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h300,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,0,0,            1,32'h400,1, 0,32'h300,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,0,0,            1,32'h500,1, 0,32'h400,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,1,32'hAAAA5555, 0,0,1, 0,32'h500,0,32'h100,I2,2));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h500,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,1,32'hCAFEF00D, 1,32'h600,1, 0,32'h500,0,32'h100,I2,2));
        tbl.push_back(mk(1,1,0,0,            0,0,1, 1,32'h600,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,0,0,            0,0,1, 0,32'h600,0,32'h100,I2,2));
        tbl.push_back(mk(1,0,0,0,            0,0,1, 0,32'h600,0,32'h100,I2,2));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst;
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
            @(negedge clk);
            ins = tbl[i].e_instr;
            check("imem_req",   i, {31'b0, bus.imem_req},  {31'b0, tbl[i].e_req});
            check("imem_addr",  i, bus.imem_addr,          tbl[i].e_addr);
            check("out_valid",  i, {31'b0, bus.out_valid}, {31'b0, tbl[i].e_valid});
            check("out_pc",     i, bus.out_pc,             tbl[i].e_pc);
            check("out_instr",  i, bus.out_instr,          ins);
            check("out_opcode", i, {26'b0, bus.out_opcode}, {26'b0, ins[31:26]});
            check("out_fn",     i, {26'b0, bus.out_fn},     {26'b0, ins[5:0]});
            check("deliv_cnt",  i, {16'b0, bus.deliv_cnt},  {16'b0, tbl[i].e_cnt});
        end

        // Asynchronous reset while in S_WAIT, away from any clock edge
        #2 rst = 0;
        #1;
        check("rst_req",   0, {31'b0, bus.imem_req},  32'd0);
        check("rst_valid", 0, {31'b0, bus.out_valid}, 32'd0);
        check("rst_pc",    0, bus.out_pc,             32'd0);
        check("rst_instr", 0, bus.out_instr,          32'd0);
        check("rst_cnt",   0, {16'b0, bus.deliv_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_rst_req",  0, {31'b0, bus.imem_req}, 32'd1);
        check("post_rst_addr", 0, bus.imem_addr,         32'd0);

        // Randomized traffic against a transaction-level model
        exp_pc = 0; exp_cnt = 0; m_pend = 0; m_wait = 0; m_addr = 0;
        s_req = bus.imem_req; s_gnt = 0; s_rv = 0; s_addr = 0; s_stab = 0;
        s_pc = 0; s_instr = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            if (s_rv) m_pend = 0;
            if (s_req && s_gnt) begin
                m_pend = 1; m_addr = s_addr; m_wait = $urandom_range(2, 0);
            end else if (m_pend && m_wait > 0) begin
                m_wait--;
            end
            #1;
            g   = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            rd  = ($urandom % 10) == 0;
            rp  = $urandom;
            rv  = m_pend && (m_wait == 0);
            drive(g, rv, memword(m_addr), rd, rp, rdy);
            @(negedge clk);
            if (s_stab) begin
                check("hold_valid", c, {31'b0, bus.out_valid}, 32'd1);
                check("hold_pc",    c, bus.out_pc,    s_pc);
                check("hold_instr", c, bus.out_instr, s_instr);
            end
            if (bus.imem_req) begin
                check("rnd_addr",   c, bus.imem_addr, exp_pc);
                check("no_prefetch", c, {31'b0, bus.out_valid}, 32'd0);
            end
            if (bus.out_valid) begin
                ins = memword(bus.out_pc);
                check("rnd_instr",  c, bus.out_instr, ins);
                check("rnd_opcode", c, {26'b0, bus.out_opcode}, {26'b0, ins[31:26]});
                check("rnd_fn",     c, {26'b0, bus.out_fn},     {26'b0, ins[5:0]});
            end
            check("rnd_cnt", c, {16'b0, bus.deliv_cnt}, {16'b0, exp_cnt});
            if (bus.out_valid && rdy && !rd) begin
                check("rnd_deliv_pc", c, bus.out_pc, exp_pc);
                exp_pc  = exp_pc + 4;
                exp_cnt = exp_cnt + 1;
            end
            if (rd) exp_pc = {rp[31:2], 2'b00};
            s_req = bus.imem_req; s_gnt = g; s_rv = rv; s_addr = bus.imem_addr;
            s_stab = bus.out_valid && !rdy && !rd;
            s_pc = bus.out_pc; s_instr = bus.out_instr;
        end
        check("rnd_progress", 0, {31'b0, (exp_cnt > 16'd20)}, 32'd1);

        // PC wrap on the instance reset to the last word of the address space
        @(posedge clk); #1;
        wbus.imem_gnt = 1;
        @(negedge clk);
        check("wrap_req0",  0, {31'b0, wbus.imem_req}, 32'd1);
        check("wrap_addr0", 0, wbus.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        wbus.imem_gnt = 0; wbus.imem_rvalid = 1; wbus.imem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        wbus.imem_rvalid = 0; wbus.out_ready = 1;
        @(negedge clk);
        check("wrap_valid", 0, {31'b0, wbus.out_valid}, 32'd1);
        check("wrap_pc",    0, wbus.out_pc, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        wbus.out_ready = 0;
        @(negedge clk);
        check("wrap_req1",  0, {31'b0, wbus.imem_req}, 32'd1);
        check("wrap_addr1", 0, wbus.imem_addr, 32'h0000_0000);
        check("wrap_cnt",   0, {16'b0, wbus.deliv_cnt}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
